// File: rtl/timing_rx.sv
// Receive-side monitor for the radar timing bus: measures CPI/PRI periods,
// sync delay and PRI count per CPI, and flags protocol violations.
module timing_rx #(
    parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        cpib,
    input  logic        cpie,
    input  logic        pri,
    input  logic        sync,
    input  logic [9:0]  exp_pri_num,
    input  logic        err_clr,
    output logic [31:0] meas_cpi_p,
    output logic [31:0] meas_pri_p,
    output logic [31:0] meas_sync_delay,
    output logic [9:0]  meas_pri_num,
    output logic        meas_valid,
    output logic        err_num,
    output logic        err_nocpie,
    output logic        err_orphan,
    output logic        err_timeout,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t      st;
    logic        cpib_q, cpie_q, pri_q, sync_q;
    logic        rise_cpib, rise_cpie, rise_pri, rise_sync;
    logic [31:0] cpi_cnt, pri_cnt;
    logic [31:0] cpi_cnt_inc, pri_cnt_inc;
    logic [9:0]  pri_num_acc, acc_next;
    logic        cpi_seen;
    logic        open_cpi;

    assign rise_cpib = cpib & ~cpib_q;
    assign rise_cpie = cpie & ~cpie_q;
    assign rise_pri  = pri  & ~pri_q;
    assign rise_sync = sync & ~sync_q;

    assign cpi_cnt_inc = (cpi_cnt == 32'hFFFF_FFFF) ? cpi_cnt : cpi_cnt + 32'd1;
    assign pri_cnt_inc = (pri_cnt == 32'hFFFF_FFFF) ? pri_cnt : pri_cnt + 32'd1;
    assign acc_next    = (rise_pri && pri_num_acc != 10'h3FF) ? pri_num_acc + 10'd1
                                                              : pri_num_acc;

    // The PRI counter also restarts when a CPI opens so the timeout measures from cpib.
    assign open_cpi = rise_cpib && (st != IDLE);

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpib_q <= 1'b0;
            cpie_q <= 1'b0;
            pri_q  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            cpib_q <= cpib;
            cpie_q <= cpie;
            pri_q  <= pri;
            sync_q <= sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st              <= IDLE;
            cpi_cnt         <= '0;
            pri_cnt         <= '0;
            pri_num_acc     <= '0;
            cpi_seen        <= 1'b0;
            meas_cpi_p      <= '0;
            meas_pri_p      <= '0;
            meas_sync_delay <= '0;
            meas_pri_num    <= '0;
            meas_valid      <= 1'b0;
            err_num         <= 1'b0;
            err_nocpie      <= 1'b0;
            err_orphan      <= 1'b0;
            err_timeout     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            // Clear first so that a set condition later in this block wins.
            if (err_clr) begin
                err_num     <= 1'b0;
                err_nocpie  <= 1'b0;
                err_orphan  <= 1'b0;
                err_timeout <= 1'b0;
            end
            if (!enable) begin
                st          <= IDLE;
                cpi_cnt     <= '0;
                pri_cnt     <= '0;
                pri_num_acc <= '0;
                cpi_seen    <= 1'b0;
            end else begin
                cpi_cnt <= rise_cpib ? 32'd0 : cpi_cnt_inc;
                pri_cnt <= (rise_pri || open_cpi) ? 32'd0 : pri_cnt_inc;
                if (st != IDLE) begin
                    if (rise_pri)
                        meas_pri_p <= pri_cnt_inc;
                    if (rise_sync)
                        meas_sync_delay <= rise_pri ? 32'd0 : pri_cnt_inc;
                    if (rise_cpib) begin
                        cpi_seen <= 1'b1;
                        if (cpi_seen)
                            meas_cpi_p <= cpi_cnt_inc;
                    end
                end
                case (st)
                    IDLE: st <= WAIT;
                    WAIT, GAP: begin
                        if (rise_cpie)
                            err_orphan <= 1'b1;
                        if (rise_cpib) begin
                            st          <= RUN;
                            pri_num_acc <= {9'd0, rise_pri};
                        end
                    end
                    RUN: begin
                        if (rise_cpie) begin
                            meas_pri_num <= acc_next;
                            meas_valid   <= 1'b1;
                            if (acc_next != exp_pri_num)
                                err_num <= 1'b1;
                            if (rise_cpib) begin
                                pri_num_acc <= {9'd0, rise_pri};
                                st          <= RUN;
                            end else begin
                                st <= GAP;
                            end
                        end else if (rise_cpib) begin
                            err_nocpie  <= 1'b1;
                            pri_num_acc <= {9'd0, rise_pri};
                        end else if (pri_cnt >= TIMEOUT) begin
                            err_timeout <= 1'b1;
                            st          <= WAIT;
                        end else begin
                            pri_num_acc <= acc_next;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/timing_rx.md
# timing_rx

Receive-side checker for the radar timing bus driven by the timing generator (cpib, cpie, pri, sync, pri_num). It sits on the same clk as the generator and measures the CPI period, PRI period, PRI count per CPI and sync delay. Each completed CPI is reported with a one-cycle valid strobe. Protocol violations raise sticky error flags for the control/status register block.

## Interface

- TIMEOUT, default 32'd1_000_000: cycles without a pri edge inside a CPI before the CPI is aborted.
- clk  in  1  system clock; all timing inputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  monitor enable; low forces IDLE.
- cpib, cpie, pri, sync  in  1 each  timing-bus levels; only rising edges are used.
- exp_pri_num  in  10  expected PRI count per CPI.
- err_clr  in  1  synchronous clear of all sticky errors.
- meas_cpi_p  out  32  last cpib-to-cpib period, in cycles.
- meas_pri_p  out  32  last pri-to-pri period, in cycles.
- meas_sync_delay  out  32  last pri-rise-to-sync-rise delay, in cycles.
- meas_pri_num  out  10  pri edges in the last completed CPI.
- meas_valid  out  1  one-cycle strobe; a CPI completed.
- err_num  out  1  sticky; meas_pri_num differed from exp_pri_num.
- err_nocpie  out  1  sticky; cpib arrived while a CPI was open.
- err_orphan  out  1  sticky; cpie arrived with no CPI open.
- err_timeout  out  1  sticky; PRI timeout fired.
- state  out  2  0 IDLE, 1 WAIT, 2 RUN, 3 GAP.

## Operation

- Edge detect: x_q is x registered; rise_x = x & ~x_q, evaluated combinationally in the first cycle x is sampled high. Every x_q resets to 0.
- Period counters (cpi, pri, sync): on the reference rise the counter loads 0, then increments by 1 each cycle and saturates at 32'hFFFF_FFFF. A capture stores cnt+1, saturating. Resulting values:
  - Edges P cycles apart give meas = P.
  - For sync, a capture stores cnt+1 measured from the last pri rise. sync rising in the same cycle as pri gives meas_sync_delay = 0.
- meas_pri_p and meas_sync_delay update in every non-IDLE state. meas_cpi_p updates on each cpib rise except the first after leaving IDLE.
- State machine:
  - IDLE: entered whenever enable=0, synchronously. All counters and pri_num_acc are cleared. meas_* and err_* hold. Moves to WAIT when enable=1.
  - WAIT: on rise_cpib, go to RUN and set pri_num_acc = rise_pri (a coincident pri counts).
  - RUN: each rise_pri increments pri_num_acc. On rise_cpie, register meas_pri_num = pri_num_acc + rise_pri, set err_num if that value ≠ exp_pri_num, pulse meas_valid next cycle, then go to GAP.
  - RUN, cpib rise without cpie: set err_nocpie, restart the CPI (pri_num_acc = rise_pri), stay in RUN, no meas_valid.
  - RUN timeout: if the pri counter reaches TIMEOUT, set err_timeout and go to WAIT.
  - GAP: rise_cpib goes to RUN as in WAIT. rise_cpie in GAP or WAIT sets err_orphan.
- pri_num_acc saturates at 10'h3FF.
- err_clr clears all err_*. If a set condition occurs in the same cycle, the set wins.

## Timing

- Reset values: every meas_* = 0, meas_valid = 0, every err_* = 0, state = IDLE.
- Capture latency: meas_* and err_* update on the clock edge that ends the detection cycle and are visible one cycle after the input rise.
- meas_valid is high in the same cycle that meas_pri_num and err_num become visible.
- Simultaneous rise_cpib and rise_cpie in RUN: close the CPI first (report, meas_valid), then open a new one, ending in RUN. No err_nocpie.
- Reset asserted mid-CPI aborts immediately with no meas_valid.
- enable dropped mid-CPI goes to IDLE next cycle with no meas_valid.

## Test plan

- CPI with cpib period 5000, pri period 100, 40 pri edges, cpie after the 40th pri, exp_pri_num=40, sync 7 cycles after each pri:
  - after the second cpib, meas_cpi_p=5000;
  - meas_pri_p=100, meas_sync_delay=7;
  - meas_valid is one cycle wide, meas_pri_num=40, err_num=0.
- Same stimulus with exp_pri_num=39 → err_num=1, and it stays 1 until err_clr; err_clr clears it in the next cycle.
- Two cpib edges with no cpie between them → err_nocpie=1, no meas_valid. The next normal CPI still reports meas_pri_num correctly.
- cpie while in WAIT → err_orphan=1, state stays WAIT.
- TIMEOUT=50, cpib followed by no pri for 50 cycles → err_timeout=1, state=WAIT. pri edges arriving afterwards are ignored until the next cpib.
- rst_n pulsed low mid-CPI → all outputs 0 immediately. enable low → IDLE with meas_* unchanged.
- pri coincident with cpib and with cpie → both edges are counted.
